// File: rtl/nf_ahb_ram_ctrl_if.sv
// nf_ahb_ram_ctrl_if: AHB-Lite slave-side bundle for the RAM controller.
// Address/control/write data from master, read data/ready/resp from slave.
interface nf_ahb_ram_ctrl_if;
  logic [31:0] haddr_s;
  logic [31:0] hwdata_s;
  logic [31:0] hrdata_s;
  logic        hwrite_s;
  logic [1:0]  htrans_s;
  logic [2:0]  hsize_s;
  logic [2:0]  hburst_s;
  logic        hsel_s;
  logic        hready_in;
  logic        hready_s;
  logic [1:0]  hresp_s;

  modport master (
    output haddr_s, hwdata_s, hwrite_s, htrans_s,
    output hsize_s, hburst_s, hsel_s, hready_in,
    input  hrdata_s, hready_s, hresp_s
  );

  modport slave (
    input  haddr_s, hwdata_s, hwrite_s, htrans_s,
    input  hsize_s, hburst_s, hsel_s, hready_in,
    output hrdata_s, hready_s, hresp_s
  );
endinterface

// File: rtl/nf_ahb_ram_ctrl.sv
// nf_ahb_ram_ctrl: AHB-Lite slave in front of a sync single-port RAM.
// Ports: hclk, hreset (sync, active-high); bus (nf_ahb_ram_ctrl_if.slave);
//   ram_addr/ram_wd/ram_be/ram_we/ram_re to the RAM, ram_rd back from it.
// Optional ERROR response: define NF_AHB_RAM_ERR_EN.
module nf_ahb_ram_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              hreset,
  nf_ahb_ram_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wd,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rd
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, ERR1, ERR2
  } state_t;

  state_t      state;
  logic        hready_r;
  logic [1:0]  hresp_r;
  logic [3:0]  be_r;
  logic [2:0]  cnt;
  logic        rd_last;

  logic        accept;
  logic        err;
  logic [3:0]  lanes;
  logic [1:0]  off;
  logic [ADDR_W-1:0] waddr;

  logic unused_bits;
  assign unused_bits = ^{bus.hburst_s, bus.htrans_s[0],
                         bus.haddr_s[31:ADDR_W+2]};

  assign off    = bus.haddr_s[1:0];
  assign waddr  = bus.haddr_s[ADDR_W+1:2];
  // htrans[1] set means NONSEQ or SEQ
  assign accept = bus.hsel_s & bus.hready_in & bus.htrans_s[1];

  // Misaligned offsets fall to the lane of the aligned container.
  always_comb begin
    lanes = 4'b1111;
    unique case (1'b1)
      (bus.hsize_s == 3'd0): lanes = 4'b0001 << off;
      (bus.hsize_s == 3'd1): lanes = off[1] ? 4'b1100 : 4'b0011;
      default:               lanes = 4'b1111;
    endcase
  end

  always_comb begin
    err = 1'b0;
`ifdef NF_AHB_RAM_ERR_EN
    if ({2'b00, bus.haddr_s[31:2]} >= 32'(DEPTH))
      err = 1'b1;
    if (bus.hsize_s > 3'd2)
      err = 1'b1;
    if (bus.hsize_s == 3'd1 && off[0])
      err = 1'b1;
    if (bus.hsize_s == 3'd2 && off != 2'b00)
      err = 1'b1;
`else
    err = 1'b0;
`endif
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= IDLE;
      hready_r <= 1'b1;
      hresp_r  <= 2'b00;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      be_r     <= '0;
      cnt      <= '0;
      rd_last  <= 1'b0;
    end else if (hready_r) begin
      // any ready cycle closes the data phase and may take a new one
      ram_re  <= 1'b0;
      rd_last <= 1'b0;
      hresp_r <= 2'b00;
      cnt     <= '0;
      if (!accept) begin
        state    <= IDLE;
        hready_r <= 1'b1;
      end else if (err) begin
        state    <= ERR1;
        hready_r <= 1'b0;
        hresp_r  <= 2'b01;
      end else if (bus.hwrite_s) begin
        state    <= WR;
        hready_r <= 1'b1;
        ram_addr <= waddr;
        be_r     <= lanes;
      end else begin
        state    <= RD;
        hready_r <= 1'b0;
        ram_re   <= 1'b1;
        ram_addr <= waddr;
        cnt      <= 3'(RD_LAT);
      end
    end else begin
      ram_re <= 1'b0;
      case (state)
        RD: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            hready_r <= 1'b1;
            rd_last  <= 1'b1;
          end
        end
        ERR1: begin
          state    <= ERR2;
          hready_r <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          hready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ram_we       = (state == WR);
  assign ram_be       = ram_we ? be_r : 4'b0000;
  assign ram_wd       = bus.hwdata_s;
  assign bus.hready_s = hready_r;
  assign bus.hresp_s  = hresp_r;
  assign bus.hrdata_s = rd_last ? ram_rd : 32'h0;

endmodule

// File: tb/tb_nf_ahb_ram_ctrl.sv
// tb_nf_ahb_ram_ctrl: directed bench for nf_ahb_ram_ctrl, DEPTH=1000, RD_LAT=2.
// Includes a behavioural 2-cycle-latency RAM; follows NF_AHB_RAM_ERR_EN.
module tb_nf_ahb_ram_ctrl;
  localparam int DEPTH  = 1000;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(DEPTH);

  logic          hclk = 1'b0;
  logic          hreset;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wd;
  logic [3:0]    ram_be;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rd;

  int checks = 0;
  int errors = 0;

  nf_ahb_ram_ctrl_if bus ();

  nf_ahb_ram_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .bus      (bus.slave),
    .ram_addr (ram_addr),
    .ram_wd   (ram_wd),
    .ram_be   (ram_be),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_rd   (ram_rd)
  );

  always #5 hclk = ~hclk;

  assign bus.hready_in = bus.hready_s;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_p1, rd_p2;

  always @(posedge hclk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
    if (ram_re) rd_p1 <= mem[ram_addr];
    rd_p2 <= rd_p1;
  end
  assign ram_rd = rd_p2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w,
                         input logic [2:0] sz);
    bus.hsel_s   = 1'b1;
    bus.htrans_s = 2'b10;
    bus.haddr_s  = a;
    bus.hwrite_s = w;
    bus.hsize_s  = sz;
  endtask

  task automatic idle_ph();
    bus.hsel_s   = 1'b0;
    bus.htrans_s = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1000] = 32'h1234_5678;
    hreset       = 1'b1;
    bus.haddr_s  = '0;
    bus.hwdata_s = '0;
    bus.hwrite_s = 1'b0;
    bus.htrans_s = 2'b00;
    bus.hsize_s  = 3'd2;
    bus.hburst_s = 3'd0;
    bus.hsel_s   = 1'b0;
    step();
    step();
    chk("rst_hready", 32'(bus.hready_s), 32'd1);
    chk("rst_hresp",  32'(bus.hresp_s),  32'd0);
    chk("rst_we",     32'(ram_we),       32'd0);
    chk("rst_re",     32'(ram_re),       32'd0);
    chk("rst_be",     32'(ram_be),       32'd0);
    chk("rst_addr",   32'(ram_addr),     32'd0);
    chk("rst_hrdata", bus.hrdata_s,      32'd0);
    hreset = 1'b0;

    // word write 0x10
    addr_ph(32'h10, 1'b1, 3'd2);
    step();
    idle_ph();
    bus.hwdata_s = 32'hDEAD_BEEF;
    #1;
    chk("wr_we",     32'(ram_we),       32'd1);
    chk("wr_be",     32'(ram_be),       32'hF);
    chk("wr_addr",   32'(ram_addr),     32'd4);
    chk("wr_hready", 32'(bus.hready_s), 32'd1);
    chk("wr_wd",     ram_wd,            32'hDEAD_BEEF);
    step();

    // word read 0x10
    addr_ph(32'h10, 1'b0, 3'd2);
    step();
    idle_ph();
    chk("rd1_re",     32'(ram_re),       32'd1);
    chk("rd1_addr",   32'(ram_addr),     32'd4);
    chk("rd1_hready", 32'(bus.hready_s), 32'd0);
    step();
    chk("rd2_hready", 32'(bus.hready_s), 32'd0);
    chk("rd2_re",     32'(ram_re),       32'd0);
    chk("rd2_hrdata", bus.hrdata_s,      32'd0);
    step();
    chk("rd3_hready", 32'(bus.hready_s), 32'd1);
    chk("rd3_hrdata", bus.hrdata_s,      32'hDEAD_BEEF);
    step();
    chk("rd4_hrdata", bus.hrdata_s,      32'd0);

    // halfword 0x12 then byte 0x13, pipelined
    addr_ph(32'h12, 1'b1, 3'd1);
    step();
    bus.hwdata_s = 32'h1234_0000;
    addr_ph(32'h13, 1'b1, 3'd0);
    #1;
    chk("hw_be", 32'(ram_be), 32'hC);
    step();
    idle_ph();
    bus.hwdata_s = 32'hAA00_0000;
    #1;
    chk("by_be", 32'(ram_be), 32'h8);
    chk("by_we", 32'(ram_we), 32'd1);
    step();
    addr_ph(32'h10, 1'b0, 3'd2);
    step();
    idle_ph();
    step();
    step();
    chk("lanes_rd", bus.hrdata_s, 32'hAA34_BEEF);
    step();

    // write 0x20 with read 0x20 in its data phase
    addr_ph(32'h20, 1'b1, 3'd2);
    step();
    bus.hwdata_s = 32'h0BAD_F00D;
    addr_ph(32'h20, 1'b0, 3'd2);
    #1;
    chk("p_wr_we", 32'(ram_we), 32'd1);
    step();
    idle_ph();
    chk("p_rd_re",   32'(ram_re),   32'd1);
    chk("p_rd_addr", 32'(ram_addr), 32'd8);
    step();
    step();
    chk("p_rd_data", bus.hrdata_s, 32'h0BAD_F00D);
    step();

    // word 1000
    addr_ph(32'hFA0, 1'b0, 3'd2);
    step();
    idle_ph();
`ifdef NF_AHB_RAM_ERR_EN
    chk("e1_hready", 32'(bus.hready_s), 32'd0);
    chk("e1_hresp",  32'(bus.hresp_s),  32'd1);
    chk("e1_re",     32'(ram_re),       32'd0);
    step();
    chk("e2_hready", 32'(bus.hready_s), 32'd1);
    chk("e2_hresp",  32'(bus.hresp_s),  32'd1);
    chk("e2_re",     32'(ram_re),       32'd0);
    step();
    chk("e3_hresp",  32'(bus.hresp_s),  32'd0);
`else
    chk("oor_re",    32'(ram_re),       32'd1);
    chk("oor_addr",  32'(ram_addr),     32'd1000);
    chk("oor_hresp", 32'(bus.hresp_s),  32'd0);
    step();
    step();
    chk("oor_hready", 32'(bus.hready_s), 32'd1);
    chk("oor_data",   bus.hrdata_s,      32'h1234_5678);
    step();
`endif

    // reset during first read wait cycle
    addr_ph(32'h10, 1'b0, 3'd2);
    step();
    idle_ph();
    chk("rr_re", 32'(ram_re), 32'd1);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    chk("rr_hready", 32'(bus.hready_s), 32'd1);
    chk("rr_re0",    32'(ram_re),       32'd0);
    chk("rr_hresp",  32'(bus.hresp_s),  32'd0);
    step();
    chk("rr_re1", 32'(ram_re), 32'd0);
    addr_ph(32'h30, 1'b1, 3'd2);
    step();
    idle_ph();
    bus.hwdata_s = 32'h55AA_55AA;
    #1;
    chk("rw_we",   32'(ram_we),   32'd1);
    chk("rw_addr", 32'(ram_addr), 32'd12);
    chk("rw_be",   32'(ram_be),   32'hF);
    step();

    // ignored cycles
    bus.hsel_s   = 1'b1;
    bus.htrans_s = 2'b00;
    bus.hwrite_s = 1'b0;
    step();
    chk("idl_re",     32'(ram_re),       32'd0);
    chk("idl_we",     32'(ram_we),       32'd0);
    chk("idl_hready", 32'(bus.hready_s), 32'd1);
    bus.hsel_s   = 1'b0;
    bus.htrans_s = 2'b10;
    bus.hwrite_s = 1'b1;
    step();
    chk("nsel_re",     32'(ram_re),       32'd0);
    chk("nsel_we",     32'(ram_we),       32'd0);
    chk("nsel_hready", 32'(bus.hready_s), 32'd1);
    idle_ph();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
